// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// bus_arb_pkg - shared FSM/owner encodings and default access length.  rev 1.0
// ============================================================================
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEFAULT_WAIT_CYCLES = 3;

endpackage
`default_nettype wire

// File: rtl/wait_state_counter.sv
`default_nettype none
// ============================================================================
// wait_state_counter - 4-bit access-length counter, holds at terminal.  rev 1.0
// ============================================================================
module wait_state_counter import bus_arb_pkg::*; #(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [3:0] TERM_COUNT = 4'(WAIT_CYCLES - 1);

    logic [3:0] count;

    assign terminal = (count == TERM_COUNT);

    // Saturates at the terminal value so a slow memory simply stretches the access.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter - CPU/DMA round-robin memory arbiter; DMA port built only with
// BUS_ARB_DMA_EN defined (otherwise CPU is the sole owner).  rev 1.0
// ============================================================================
module bus_arbiter import bus_arb_pkg::*; #(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_grant,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_rnw,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_oe,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    arb_state_t state;
    arb_state_t state_next;
    owner_t     owner;
    owner_t     last_owner;
    owner_t     pick;
    logic       rnw;
    logic       terminal;
    logic       dma_req_eff;
    logic       dma_strobe;
    logic       start;
    logic       rd_capture;

`ifdef BUS_ARB_DMA_EN
    assign dma_req_eff = dma_req;
`else
    assign dma_req_eff = 1'b0;
`endif

    assign start      = (state == IDLE) && (cpu_req || dma_req_eff);
    assign rd_capture = (state == ACCESS) && terminal && mem_ready && rnw;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = OWN_CPU;
        if (dma_req_eff && (!cpu_req || last_owner == OWN_CPU)) begin
            pick = OWN_DMA;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_oe     = 1'b0;
        mem_we     = 1'b0;
        cpu_grant  = 1'b0;
        dma_strobe = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCESS;
            end
            ACCESS: begin
                mem_oe = rnw;
                mem_we = ~rnw;
                if (terminal && mem_ready) state_next = COMPLETE;
            end
            COMPLETE: begin
                cpu_grant  = (owner == OWN_CPU);
                dma_strobe = (owner == OWN_DMA);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    wait_state_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk      (clk),
        .nrst     (nrst),
        .clear    (state != ACCESS),
        .enable   (state == ACCESS),
        .terminal (terminal)
    );

    // mem_addr/mem_wdata double as the latched request, so they hold between accesses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;
            rnw        <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            if (start) begin
                owner      <= pick;
                last_owner <= pick;
                if (pick == OWN_DMA) begin
                    rnw       <= dma_rnw;
                    mem_addr  <= dma_addr;
                    mem_wdata <= dma_wdata;
                end else begin
                    rnw       <= cpu_rnw;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
            end
            if (rd_capture && owner == OWN_CPU) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

`ifdef BUS_ARB_DMA_EN
    assign dma_ack = dma_strobe;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dma_rdata <= '0;
        end else if (rd_capture && owner == OWN_DMA) begin
            dma_rdata <= mem_rdata;
        end
    end
`else
    logic unused_dma;

    assign dma_ack    = 1'b0;
    assign dma_rdata  = '0;
    assign unused_dma = ^{dma_req, dma_strobe};
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bus_arbiter - randomized self-checking bench for bus_arbiter; adapts to
// BUS_ARB_DMA_EN.  rev 1.0
// ============================================================================
module tb_bus_arbiter;

    localparam int WAIT = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cpu_req, cpu_rnw, dma_req, dma_rnw;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_grant, dma_ack, mem_we, mem_oe, mem_ready;
    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bus_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) tick();
        nrst = 1'b1;
        tick();
    endtask

    // Runs one access whose request is sampled at the next edge (cycle 0); cycle n is
    // observed #1 after the n-th following edge. The model: the access may end in any
    // cycle n >= WAIT where ready is high, giving a strobe in cycle n+1.
    task automatic run_txn(input int stall, input bit rnd_ready, input bit rd_rand,
                           input logic [7:0] rd_val, input logic [15:0] exp_addr,
                           input logic [7:0] exp_wdata, input bit release_req,
                           output int strobe_cyc, output bit got_dma, output int oe_cnt,
                           output int we_cnt, output int bad_cnt, output int exp_cyc,
                           output logic [7:0] exp_rd);
        bit rdy;
        strobe_cyc = -1; got_dma = 1'b0; oe_cnt = 0; we_cnt = 0; bad_cnt = 0;
        exp_cyc = -1; exp_rd = '0;
        for (int n = 1; n <= 40 && strobe_cyc < 0; n++) begin
            tick();
            if (mem_oe) oe_cnt++;
            if (mem_we) we_cnt++;
            if (cpu_grant && dma_ack) bad_cnt++;
            if ((mem_oe || mem_we || cpu_grant || dma_ack) &&
                (mem_addr !== exp_addr || mem_wdata !== exp_wdata)) bad_cnt++;
            if (cpu_grant || dma_ack) begin
                strobe_cyc = n;
                got_dma    = dma_ack;
                if (release_req) begin cpu_req = 1'b0; dma_req = 1'b0; end
            end
            rdy       = rnd_ready ? ($urandom_range(0, 1) == 1 || n >= WAIT + 8) : (n >= WAIT + stall);
            mem_ready = rdy;
            mem_rdata = rd_rand ? 8'($urandom) : rd_val;
            if (exp_cyc < 0 && n >= WAIT && rdy) begin
                exp_cyc = n + 1;
                exp_rd  = mem_rdata;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; cpu_rnw = 1'b1; dma_rnw = 1'b1;
        cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({cpu_grant, dma_ack, mem_we, mem_oe} !== 4'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000", {cpu_grant, dma_ack, mem_we, mem_oe});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 40'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        nrst = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({cpu_grant, dma_ack, mem_we, mem_oe} !== 4'b0) begin
            n_fail++; $display("FAIL idle_no_req: got %b want 0000", {cpu_grant, dma_ack, mem_we, mem_oe});
        end
    endtask

    task automatic test_cpu_read();
        int sc, oe, we, bad, ec; bit gd; logic [7:0] er, wd;
        wd = 8'($urandom);
        cpu_rnw = 1'b1; cpu_addr = 16'h1234; cpu_wdata = wd; cpu_req = 1'b1;
        run_txn(0, 1'b0, 1'b0, 8'hA5, 16'h1234, wd, 1'b1, sc, gd, oe, we, bad, ec, er);
        n_tests++;
        if (sc !== WAIT + 1 || gd !== 1'b0) begin
            n_fail++; $display("FAIL cpu_read_latency: got cyc %0d dma %0b want cyc %0d dma 0", sc, gd, WAIT + 1);
        end
        n_tests++;
        if (oe !== WAIT || we !== 0 || bad !== 0) begin
            n_fail++; $display("FAIL cpu_read_bus: got oe %0d we %0d bad %0d want %0d 0 0", oe, we, bad, WAIT);
        end
        n_tests++;
        if (cpu_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL cpu_read_data: got %h want a5", cpu_rdata);
        end
        tick();
        n_tests++;
        if (mem_oe !== 1'b0 || mem_addr !== 16'h1234 || cpu_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL cpu_read_hold: got oe %b addr %h rd %h want 0 1234 a5", mem_oe, mem_addr, cpu_rdata);
        end
    endtask

`ifdef BUS_ARB_DMA_EN
    task automatic test_dma_write();
        int sc, oe, we, bad, ec; bit gd; logic [7:0] er;
        dma_rnw = 1'b0; dma_addr = 16'h0200; dma_wdata = 8'h3C; dma_req = 1'b1;
        run_txn(0, 1'b0, 1'b1, 8'h00, 16'h0200, 8'h3C, 1'b1, sc, gd, oe, we, bad, ec, er);
        n_tests++;
        if (sc !== WAIT + 1 || gd !== 1'b1) begin
            n_fail++; $display("FAIL dma_write_latency: got cyc %0d dma %0b want cyc %0d dma 1", sc, gd, WAIT + 1);
        end
        n_tests++;
        if (we !== WAIT || oe !== 0 || bad !== 0) begin
            n_fail++; $display("FAIL dma_write_bus: got we %0d oe %0d bad %0d want %0d 0 0", we, oe, bad, WAIT);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int sc, oe, we, bad, ec; bit gd; logic [7:0] er;
        do_reset();
        cpu_rnw = 1'b1; cpu_addr = 16'hC0DE; cpu_wdata = 8'h11;
        dma_rnw = 1'b0; dma_addr = 16'hD0A0; dma_wdata = 8'h22;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn(0, 1'b0, 1'b1, 8'h00, (k % 2 == 1) ? 16'hD0A0 : 16'hC0DE,
                    (k % 2 == 1) ? 8'h22 : 8'h11, 1'b0, sc, gd, oe, we, bad, ec, er);
            n_tests++;
            if (gd !== (k % 2 == 1) || sc !== WAIT + 1 || bad !== 0) begin
                n_fail++; $display("FAIL round_robin_%0d: got dma %0b cyc %0d bad %0d want dma %0b cyc %0d bad 0",
                                   k, gd, sc, bad, (k % 2 == 1), WAIT + 1);
            end
            tick();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_dma();
        int sc, oe, we, bad, ec, prev; bit gd; logic [7:0] er;
        do_reset();
        cpu_rnw = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h00;
        dma_rnw = 1'b0; dma_addr = 16'h8000; dma_wdata = 8'hFF;
        cpu_req = 1'b1; dma_req = 1'b1;
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            run_txn(0, 1'b0, 1'b1, 8'h00, 16'h4000, 8'h00, 1'b0, sc, gd, oe, we, bad, ec, er);
            n_tests++;
            if (gd !== 1'b0 || dma_ack !== 1'b0 || sc !== WAIT + 1 || bad !== 0 || cpu_rdata !== er) begin
                n_fail++; $display("FAIL no_dma_%0d: got dma %0b cyc %0d bad %0d rd %h want 0 %0d 0 %h",
                                   k, gd, sc, bad, cpu_rdata, WAIT + 1, er);
            end
            if (prev >= 0) begin
                n_tests++;
                if (cyc - prev !== WAIT + 2) begin
                    n_fail++; $display("FAIL no_dma_period: got %0d want %0d", cyc - prev, WAIT + 2);
                end
            end
            prev = cyc;
            tick();
        end
        n_tests++;
        if (dma_rdata !== 8'h00) begin
            n_fail++; $display("FAIL no_dma_rdata: got %h want 00", dma_rdata);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
    endtask
`endif

    task automatic test_ready_stall();
        int sc, oe, we, bad, ec; bit gd; logic [7:0] er;
        cpu_rnw = 1'b1; cpu_addr = 16'h0F0F; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        run_txn(2, 1'b0, 1'b0, 8'h69, 16'h0F0F, 8'h5A, 1'b1, sc, gd, oe, we, bad, ec, er);
        n_tests++;
        if (sc !== WAIT + 3 || oe !== WAIT + 2 || bad !== 0) begin
            n_fail++; $display("FAIL ready_stall: got cyc %0d oe %0d bad %0d want %0d %0d 0", sc, oe, bad, WAIT + 3, WAIT + 2);
        end
        n_tests++;
        if (cpu_rdata !== 8'h69) begin
            n_fail++; $display("FAIL ready_stall_data: got %h want 69", cpu_rdata);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int sc, oe, we, bad, ec, strobes; bit gd; logic [7:0] er;
        mem_ready = 1'b1;
        cpu_rnw = 1'b1; cpu_addr = 16'hBEEF; cpu_wdata = 8'h77; cpu_req = 1'b1;
        tick();
        tick();
        #2 nrst = 1'b0;
        #1;
        cpu_req = 1'b0;
        n_tests++;
        if ({cpu_grant, dma_ack, mem_oe, mem_we} !== 4'b0 || {mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 40'h0) begin
            n_fail++; $display("FAIL abort_outputs: got %b %h want 0 0", {cpu_grant, dma_ack, mem_oe, mem_we},
                               {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        tick();
        nrst = 1'b1;
        strobes = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cpu_grant || dma_ack || mem_oe || mem_we) strobes++;
        end
        n_tests++;
        if (strobes !== 0) begin
            n_fail++; $display("FAIL abort_no_strobe: got %0d active cycles want 0", strobes);
        end
        cpu_addr = 16'h1357; cpu_req = 1'b1;
        run_txn(0, 1'b0, 1'b0, 8'hC3, 16'h1357, 8'h77, 1'b1, sc, gd, oe, we, bad, ec, er);
        n_tests++;
        if (sc !== WAIT + 1 || gd !== 1'b0 || bad !== 0 || cpu_rdata !== 8'hC3) begin
            n_fail++; $display("FAIL abort_recover: got cyc %0d dma %0b bad %0d rd %h want %0d 0 0 c3",
                               sc, gd, bad, cpu_rdata, WAIT + 1);
        end
        tick();
    endtask

    task automatic test_random();
        int sc, oe, we, bad, ec; bit gd, cpu_on, dma_on, exp_dma, last_dma, rnw_w;
        logic [7:0] er, m_cpu_rd, m_dma_rd, wd_w;
        logic [15:0] ad_w;
        do_reset();
        last_dma = 1'b1; m_cpu_rd = '0; m_dma_rd = '0;
        for (int t = 0; t < 24; t++) begin
            cpu_on = 1'($urandom); dma_on = 1'($urandom);
`ifdef BUS_ARB_DMA_EN
            if (!cpu_on && !dma_on) cpu_on = 1'b1;
            exp_dma = (cpu_on && dma_on) ? !last_dma : dma_on;
`else
            cpu_on  = 1'b1;
            exp_dma = 1'b0;
`endif
            cpu_rnw = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            dma_rnw = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
            rnw_w = exp_dma ? dma_rnw : cpu_rnw;
            ad_w  = exp_dma ? dma_addr : cpu_addr;
            wd_w  = exp_dma ? dma_wdata : cpu_wdata;
            cpu_req = cpu_on; dma_req = dma_on;
            run_txn(0, 1'b1, 1'b1, 8'h00, ad_w, wd_w, 1'b1, sc, gd, oe, we, bad, ec, er);
            last_dma = exp_dma;
            if (rnw_w && exp_dma) m_dma_rd = er;
            if (rnw_w && !exp_dma) m_cpu_rd = er;
            n_tests++;
            if (gd !== exp_dma || sc !== ec || bad !== 0) begin
                n_fail++; $display("FAIL rand_%0d_owner: got dma %0b cyc %0d bad %0d want dma %0b cyc %0d bad 0",
                                   t, gd, sc, bad, exp_dma, ec);
            end
            n_tests++;
            if (oe !== (rnw_w ? ec - 1 : 0) || we !== (rnw_w ? 0 : ec - 1)) begin
                n_fail++; $display("FAIL rand_%0d_bus: got oe %0d we %0d want rnw %0b for %0d cycles", t, oe, we, rnw_w, ec - 1);
            end
            n_tests++;
`ifdef BUS_ARB_DMA_EN
            if (cpu_rdata !== m_cpu_rd || dma_rdata !== m_dma_rd) begin
`else
            if (cpu_rdata !== m_cpu_rd || dma_rdata !== 8'h00) begin
`endif
                n_fail++; $display("FAIL rand_%0d_rdata: got cpu %h dma %h want cpu %h dma %h",
                                   t, cpu_rdata, dma_rdata, m_cpu_rd, m_dma_rd);
            end
            repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_read();
`ifdef BUS_ARB_DMA_EN
        test_dma_write();
        test_round_robin();
`endif
        test_ready_stall();
        test_reset_abort();
`ifndef BUS_ARB_DMA_EN
        test_no_dma();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
